// File: rtl/imem_loader_if.sv
// Byte-stream ingress and instruction-memory write bus of the loader.
// slave is the loader's view; master is the producer/memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic          clk,
    input  logic          R,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [ADDR_W:0] word_cnt
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA,
        S_LAST, S_CHK, S_DONE, S_ERR
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CHK;
    localparam state_t S_FIN = S_CHK;
`else
    localparam state_t S_END = S_DONE;
    localparam state_t S_FIN = S_LAST;
`endif

    localparam logic [16:0]       DEPTH = 17'(2 ** ADDR_W);
    localparam logic [ADDR_W:0]   ONE   = 1;
    localparam logic [ADDR_W-1:0] A_ONE = 1;

    state_t            state, nxt;
    logic              rdy, xfer, last, ck_ok;
    logic [7:0]        len_hi;
    logic [15:0]       len_n;
    logic [ADDR_W:0]   len;
    logic [1:0]        bidx;
    logic [ADDR_W-1:0] waddr;
    logic [23:0]       wbuf;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;

    assign rdy   = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                   (state == S_DATA)   || (state == S_CHK);
    assign xfer  = bus.in_valid && rdy;
    assign len_n = {len_hi, bus.in_data};
    assign last  = (word_cnt + ONE) == len;

    assign bus.in_ready  = rdy;
    assign bus.mem_we    = we_q;
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = wdata_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    assign ck_ok = bus.in_data == csum;

    always_ff @(posedge clk) begin
        if (R)
            csum <= 8'h00;
        else if (xfer && state == S_DATA)
            csum <= csum ^ bus.in_data;
    end
`else
    assign ck_ok = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (R)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt      = state;
        core_rst = 1'b1;
        busy     = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer)
                    nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_n == 16'd0)
                        nxt = S_END;
                    else if ({1'b0, len_n} > DEPTH)
                        nxt = S_ERR;
                    else
                        nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer && bidx == 2'd3 && last)
                    nxt = S_FIN;
            end
            // Final write cycle: core stays in reset until it retires.
            S_LAST: nxt = S_DONE;
            S_CHK: begin
                if (xfer)
                    nxt = ck_ok ? S_DONE : S_ERR;
            end
            S_DONE: begin
                busy     = 1'b0;
                done     = 1'b1;
                core_rst = 1'b0;
            end
            S_ERR: begin
                busy = 1'b0;
                err  = 1'b1;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (R) begin
            len_hi   <= 8'h00;
            len      <= '0;
            bidx     <= 2'd0;
            waddr    <= '0;
            wbuf     <= 24'h0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= 32'h0;
            word_cnt <= '0;
        end else begin
            we_q <= 1'b0;
            if (xfer && state == S_LEN_HI)
                len_hi <= bus.in_data;
            if (xfer && state == S_LEN_LO) begin
                len   <= len_n[ADDR_W:0];
                bidx  <= 2'd0;
                waddr <= '0;
            end
            if (xfer && state == S_DATA) begin
                bidx <= bidx + 2'd1;
                wbuf <= {wbuf[15:0], bus.in_data};
                if (bidx == 2'd3) begin
                    we_q     <= 1'b1;
                    waddr_q  <= waddr;
                    wdata_q  <= {wbuf, bus.in_data};
                    waddr    <= waddr + A_ONE;
                    word_cnt <= word_cnt + ONE;
                end
            end
        end
    end
endmodule
